// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl: synchronizes, latches, masks and fixed-priority arbitrates external
// interrupt lines into one held one-hot request. Define IRQ_LEVEL_EN for level-sensitive lines.
module irq_source_ctrl #(
  parameter int NIRQ        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wdata,
  output logic [NIRQ-1:0] mask_q,
  input  logic            clr_we,
  input  logic [NIRQ-1:0] clr_wdata,
  output logic [NIRQ-1:0] pending_q,
  input  logic            irq_ack,
  output logic [NIRQ-1:0] irq_req,
  output logic            irq_valid,
  output logic [4:0]      irq_id,
  input  logic            lvl_we,
  input  logic [NIRQ-1:0] lvl_wdata,
  output logic [NIRQ-1:0] lvl_q
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

  state_e                           state_q, state_d;
  logic [SYNC_STAGES-1:0][NIRQ-1:0] sync_q, sync_d;
  logic [NIRQ-1:0]                  hist_q, hist_d, rise_q, rise_d;
  logic [NIRQ-1:0]                  mask_d, pending_d;
  logic [NIRQ-1:0]                  grant_q, grant_d;
  logic [NIRQ-1:0]                  eligible, win_oh, ack_clr;
  logic [4:0]                       irq_id_q, irq_id_d, win_id;

  // Edge detect is registered, adding one cycle after the synchronizer.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
    hist_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

`ifdef IRQ_LEVEL_EN
  logic [NIRQ-1:0] lvl_d;

  always_comb begin
    lvl_d = lvl_we ? lvl_wdata : lvl_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_q <= '0;
    else     lvl_q <= lvl_d;
  end
`else
  logic unused_lvl;
  assign unused_lvl = ^{lvl_we, lvl_wdata};
  assign lvl_q      = '0;
`endif

  // Priority: set from edge beats ack clear beats software clear; level lines track hist.
  always_comb begin
    ack_clr   = (state_q == REQ && irq_ack) ? grant_q : '0;
    pending_d = pending_q & ~(clr_we ? clr_wdata : '0);
    pending_d = (pending_d & ~ack_clr) | rise_q;
    pending_d = (pending_d & ~lvl_q) | (hist_q & lvl_q);
    mask_d    = mask_we ? mask_wdata : mask_q;
  end

  always_comb begin
    eligible = pending_q & mask_q;
    win_oh   = '0;
    win_id   = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_id    = 5'(i);
      end
    end
  end

  always_comb begin
    grant_d  = grant_q;
    irq_id_d = irq_id_q;
    if (state_q == IDLE && |eligible) begin
      grant_d  = win_oh;
      irq_id_d = win_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      hist_q    <= '0;
      rise_q    <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      grant_q   <= '0;
      irq_id_q  <= '0;
      state_q   <= IDLE;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      rise_q    <= rise_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      grant_q   <= grant_d;
      irq_id_q  <= irq_id_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|eligible) state_d = REQ;
      REQ:     if (irq_ack)   state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // GAP forces a return-to-zero on the request before the next grant.
  always_comb begin
    irq_req   = (state_q == REQ) ? grant_q : '0;
    irq_valid = |irq_req;
    irq_id    = irq_id_q;
  end

endmodule

// File: tb/tb_irq_source_ctrl.sv
// tb_irq_source_ctrl: directed test-plan sequences plus randomized traffic, each cycle
// compared against a delay-line/queue reference model of the interrupt front end.
module tb_irq_source_ctrl;

  localparam int SYNC = 2;
  localparam int D    = SYNC + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] irq_in, mask_wdata, clr_wdata, lvl_wdata;
  logic        mask_we, clr_we, irq_ack, lvl_we;
  logic [31:0] mask_q, pending_q, irq_req, lvl_q;
  logic        irq_valid;
  logic [4:0]  irq_id;

  irq_source_ctrl #(.NIRQ(32), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .mask_q(mask_q),
    .clr_we(clr_we), .clr_wdata(clr_wdata), .pending_q(pending_q),
    .irq_ack(irq_ack), .irq_req(irq_req), .irq_valid(irq_valid), .irq_id(irq_id),
    .lvl_we(lvl_we), .lvl_wdata(lvl_wdata), .lvl_q(lvl_q)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: h[j] is the irq_in sample taken j+1 edges ago.
  logic [31:0] h [0:D];
  logic [31:0] m_pend, m_mask, m_lvl, m_req;
  bit          m_busy;
  int          m_cool;
  int          m_id;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j <= D; j++) h[j] = '0;
    m_pend = '0; m_mask = '1; m_lvl = '0; m_req = '0;
    m_busy = 0; m_cool = 0; m_id = 0;
  endtask

  task automatic model_step();
    logic [31:0] elig, rise, nxt, ackc;
    elig = m_pend & m_mask;
    rise = h[D-1] & ~h[D];
    ackc = (m_busy && irq_ack) ? m_req : 32'h0;
    nxt  = m_pend;
    if (clr_we) nxt = nxt & ~clr_wdata;
    nxt = (nxt & ~ackc) | rise;
`ifdef IRQ_LEVEL_EN
    nxt = (nxt & ~m_lvl) | (h[D-1] & m_lvl);
    if (lvl_we) m_lvl = lvl_wdata;
`endif
    if (m_busy) begin
      if (irq_ack) begin m_busy = 0; m_cool = 1; end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (elig != 0) begin
      m_req  = elig & (~elig + 32'd1);
      for (int i = 31; i >= 0; i--) if (elig[i]) m_id = i;
      m_busy = 1;
    end
    m_pend = nxt;
    if (mask_we) m_mask = mask_wdata;
    for (int j = D; j > 0; j--) h[j] = h[j-1];
    h[0] = irq_in;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("req",   irq_req,   m_busy ? m_req : 32'h0);
    chk("valid", {31'h0, irq_valid}, {31'h0, m_busy});
    chk("pend",  pending_q, m_pend);
    chk("mask",  mask_q,    m_mask);
    chk("lvl",   lvl_q,     m_lvl);
    if (m_busy) chk("id", {27'h0, irq_id}, m_id);
  endtask

  task automatic wait_valid(input int lim);
    int k = 0;
    while (!irq_valid && k < lim) begin cyc(); k++; end
    chk("wait_valid", {31'h0, irq_valid}, 32'h1);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      irq_ack = irq_valid;
      cyc();
    end
    irq_ack = 0;
  endtask

  initial begin
    int ids [3] = '{3, 8, 10};
    int grants;
    rst = 1; irq_in = 0; mask_we = 0; mask_wdata = 0; clr_we = 0; clr_wdata = 0;
    irq_ack = 0; lvl_we = 0; lvl_wdata = 0;
    model_reset();
    #22;
    chk("rst_mask",  mask_q,    32'hFFFF_FFFF);
    chk("rst_pend",  pending_q, 32'h0);
    chk("rst_req",   irq_req,   32'h0);
    chk("rst_valid", {31'h0, irq_valid}, 32'h0);
    chk("rst_lvl",   lvl_q,     32'h0);
    chk("rst_id",    {27'h0, irq_id}, 32'h0);
    rst = 0;

    // Single pulse on line 2: pending after 3 edges, request after 4.
    irq_in = 32'h4; cyc(); irq_in = 0;
    cyc(); cyc(); cyc();
    chk("t1_pend3",  pending_q, 32'h4);
    chk("t1_valid3", {31'h0, irq_valid}, 32'h0);
    cyc();
    chk("t1_req4", irq_req, 32'h4);
    chk("t1_id4",  {27'h0, irq_id}, 32'd2);
    irq_ack = 1; cyc(); irq_ack = 0;
    chk("t1_req_ack",  irq_req,   32'h0);
    chk("t1_pend_ack", pending_q, 32'h0);
    cyc();
    chk("t1_gap", irq_req, 32'h0);

    // Three simultaneous edges granted lowest index first.
    irq_in = 32'h508; cyc(); irq_in = 0;
    for (int g = 0; g < 3; g++) begin
      wait_valid(20);
      chk("t2_order", {27'h0, irq_id}, ids[g]);
      irq_ack = 1; cyc(); irq_ack = 0;
      chk("t2_rtz", irq_req, 32'h0);
    end
    cyc(); cyc();

    // Masked line latches but is not granted until unmasked.
    mask_we = 1; mask_wdata = 32'hFFFF_FFFB; cyc(); mask_we = 0;
    irq_in = 32'h4; cyc(); irq_in = 0;
    for (int k = 0; k < 5; k++) cyc();
    chk("t3_pend",  pending_q, 32'h4);
    chk("t3_valid", {31'h0, irq_valid}, 32'h0);
    mask_we = 1; mask_wdata = 32'hFFFF_FFFF; cyc(); mask_we = 0;
    chk("t3_nogrant_yet", irq_req, 32'h0);
    cyc();
    chk("t3_req", irq_req, 32'h4);
    irq_ack = 1; cyc(); irq_ack = 0;
    cyc(); cyc();

    // New edge on the granted line lands on the ack edge; then clr_we cannot drop a request.
    irq_in = 32'h1; cyc(); irq_in = 0;
    wait_valid(20);
    for (int k = 0; k < 3; k++) cyc();
    irq_in = 32'h1; cyc(); irq_in = 0;
    cyc(); cyc();
    irq_ack = 1; cyc(); irq_ack = 0;
    chk("t4_pend_kept", pending_q & 32'h1, 32'h1);
    chk("t4_rtz", irq_req, 32'h0);
    cyc(); cyc();
    chk("t4_regrant", irq_req, 32'h1);
    clr_we = 1; clr_wdata = 32'h1; cyc(); clr_we = 0;
    chk("t4_clr_pend", pending_q & 32'h1, 32'h0);
    chk("t4_clr_held", irq_req, 32'h1);
    cyc();
    chk("t4_held2", irq_req, 32'h1);
    irq_ack = 1; cyc(); irq_ack = 0;
    chk("t4_release", irq_req, 32'h0);
    cyc(); cyc();

    // Asynchronous reset while a request is up.
    mask_we = 1; mask_wdata = 32'h0000_FFFF; cyc(); mask_we = 0;
    irq_in = 32'h20; cyc(); irq_in = 0;
    wait_valid(20);
    chk("t5_req", irq_req, 32'h20);
    rst = 1; #1;
    chk("t5_req_rst",   irq_req,   32'h0);
    chk("t5_pend_rst",  pending_q, 32'h0);
    chk("t5_valid_rst", {31'h0, irq_valid}, 32'h0);
    chk("t5_mask_rst",  mask_q,    32'hFFFF_FFFF);
    #1; rst = 0;
    model_reset();
    cyc();

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      irq_in     = ($urandom % 4 == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
      mask_we    = ($urandom % 25 == 0);
      mask_wdata = $urandom | $urandom;
      clr_we     = ($urandom % 15 == 0);
      clr_wdata  = $urandom;
      irq_ack    = irq_valid ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
      lvl_we     = ($urandom % 40 == 0);
      lvl_wdata  = $urandom & $urandom;
      cyc();
    end
    irq_in = 0; clr_we = 0; lvl_we = 0;
    mask_we = 1; mask_wdata = 32'hFFFF_FFFF; lvl_we = 1; lvl_wdata = 32'h0; cyc();
    mask_we = 0; lvl_we = 0;
    drain(200);
    chk("rnd_drained", pending_q, 32'h0);

`ifdef IRQ_LEVEL_EN
    lvl_we = 1; lvl_wdata = 32'h15; cyc(); lvl_we = 0;
    irq_in = 32'h15;
    grants = 0;
    for (int k = 0; k < 40; k++) begin
      irq_ack = irq_valid;
      if (irq_valid) grants++;
      cyc();
    end
    chk("lvl_regrant", {31'h0, grants >= 4}, 32'h1);
    irq_in = 0;
    drain(20);
    chk("lvl_quiet_valid", {31'h0, irq_valid}, 32'h0);
    chk("lvl_quiet_pend",  pending_q, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
